// File: rtl/keypad_conditioner.sv
// Conditions the raw breakout-board keys: per-key 2-flop synchronizer and debounce filter,
// a registered lowest-index note encoder with change strobe, and rising-edge event pulses.
module keypad_conditioner #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] keypad_raw,
  output logic [16:0] keys_stable,
  output logic        note_valid,
  output logic [3:0]  note_idx,
  output logic        note_strobe,
  output logic        oct_up_pulse,
  output logic        oct_dn_pulse,
  output logic        mode_pulse,
  output logic        goof_pulse
);

  localparam int unsigned NumKeys = 17;
  localparam int unsigned NumNotes = 13;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  logic [NumKeys-1:0]            sync1_q, sync2_q;
  logic [NumKeys-1:0]            stable_q, stable_d;
  logic [NumKeys-1:0]            prev_q;
  logic [NumKeys-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic       enc_valid;
  logic [3:0] enc_idx;
  logic       note_valid_q;
  logic [3:0] note_idx_q;
  logic       note_strobe_q, note_strobe_d;
  logic [3:0] pulse_q, pulse_d;
  logic [NumKeys-1:0] rise;

  // Debounce: stable flips only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NumKeys; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Lowest set note index wins.
  always_comb begin
    enc_valid = |stable_q[NumNotes-1:0];
    enc_idx   = '0;
    for (int i = NumNotes - 1; i >= 0; i--) begin
      if (stable_q[i]) begin
        enc_idx = 4'(i);
      end
    end
  end

  always_comb begin
    note_strobe_d = ({enc_valid, enc_idx} != {note_valid_q, note_idx_q});
    rise          = stable_q & ~prev_q;
    pulse_d       = rise[16:13];
    // Both octave keys rising together is ambiguous, so neither is reported.
    if (rise[16] && rise[15]) begin
      pulse_d[3:2] = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      cnt_q         <= '0;
      prev_q        <= '0;
      note_valid_q  <= 1'b0;
      note_idx_q    <= '0;
      note_strobe_q <= 1'b0;
      pulse_q       <= '0;
    end else begin
      sync1_q       <= keypad_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      cnt_q         <= cnt_d;
      prev_q        <= stable_q;
      note_valid_q  <= enc_valid;
      note_idx_q    <= enc_idx;
      note_strobe_q <= note_strobe_d;
      pulse_q       <= pulse_d;
    end
  end

  assign keys_stable  = stable_q;
  assign note_valid   = note_valid_q;
  assign note_idx     = note_idx_q;
  assign note_strobe  = note_strobe_q;
  assign oct_up_pulse = pulse_q[3];
  assign oct_dn_pulse = pulse_q[2];
  assign mode_pulse   = pulse_q[1];
  assign goof_pulse   = pulse_q[0];

endmodule

// File: tb/tb_keypad_conditioner.sv
// Scoreboard bench for keypad_conditioner with DB_CYCLES=4: expected events (strobe/pulses)
// are queued with their arrival cycle by the stimulus and consumed by a negedge monitor.
module tb_keypad_conditioner;

  logic        clk;
  logic        rst;
  logic [16:0] raw;
  logic [16:0] keys_stable;
  logic        note_valid;
  logic [3:0]  note_idx;
  logic        note_strobe;
  logic        oct_up_pulse, oct_dn_pulse, mode_pulse, goof_pulse;

  keypad_conditioner #(
    .DB_CYCLES(4),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keypad_raw  (raw),
    .keys_stable (keys_stable),
    .note_valid  (note_valid),
    .note_idx    (note_idx),
    .note_strobe (note_strobe),
    .oct_up_pulse(oct_up_pulse),
    .oct_dn_pulse(oct_dn_pulse),
    .mode_pulse  (mode_pulse),
    .goof_pulse  (goof_pulse)
  );

  typedef struct {
    int          cyc;
    logic [26:0] ev;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [26:0] obs;

  assign obs = {note_strobe, note_valid, note_idx,
                oct_up_pulse, oct_dn_pulse, mode_pulse, goof_pulse, keys_stable};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [26:0] mk(input logic strobe, input logic valid,
                                     input logic [3:0] idx, input logic [3:0] pulses,
                                     input logic [16:0] stable);
    return {strobe, valid, idx, pulses, stable};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic push(input int at, input logic [26:0] ev, input string name);
    exp_t e;
    e.cyc  = at;
    e.ev   = ev;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe or pulse must match the head of the scoreboard, on its cycle.
  always @(negedge clk) begin
    if (!rst && (note_strobe || oct_up_pulse || oct_dn_pulse || mode_pulse || goof_pulse)) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got %0h at cycle %0d expected no event", obs, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_value"}, 64'(obs), 64'(e.ev));
        check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    logic [16:0] v;
    int c;
    rst = 1'b1;
    raw = '0;
    settle(3);
    check("reset_state", 64'(obs), 64'd0);
    rst = 1'b0;
    settle(3);
    check("idle_after_reset", 64'(obs), 64'd0);

    // 1: single note press, latency check on keys_stable
    raw = 17'h00008; c = cyc;
    push(c + 7, mk(1'b1, 1'b1, 4'd3, 4'b0000, 17'h00008), "t1_press");
    settle(5);
    check("t1_stable_not_yet", 64'(keys_stable[3]), 64'd0);
    settle(1);
    check("t1_stable_flip", 64'(keys_stable[3]), 64'd1);
    settle(8);
    raw = '0; c = cyc;
    push(c + 7, mk(1'b1, 1'b0, 4'd0, 4'b0000, 17'h0), "t1_release");
    settle(10);

    // 2: two 3-cycle glitches on key 5; neither may flip
    raw = 17'h00020; settle(3);
    raw = '0;        settle(6);
    raw = 17'h00020; settle(3);
    raw = '0;        settle(10);
    check("t2_glitch_stable", 64'(keys_stable), 64'd0);

    // 3: priority and release ordering
    raw = 17'h00084; c = cyc;
    push(c + 7, mk(1'b1, 1'b1, 4'd2, 4'b0000, 17'h00084), "t3_two_keys");
    settle(10);
    raw = 17'h00080; c = cyc;
    push(c + 7, mk(1'b1, 1'b1, 4'd7, 4'b0000, 17'h00080), "t3_release_low");
    settle(10);
    raw = '0; c = cyc;
    push(c + 7, mk(1'b1, 1'b0, 4'd0, 4'b0000, 17'h0), "t3_release_all");
    settle(10);
    check("t3_idx_cleared", 64'({note_valid, note_idx}), 64'd0);

    // 4: held oct up gives one pulse; simultaneous octave rise suppressed, mode still fires
    raw = 17'h10000; c = cyc;
    push(c + 7, mk(1'b0, 1'b0, 4'd0, 4'b1000, 17'h10000), "t4_oct_up");
    settle(100);
    raw = '0; settle(10);
    raw = 17'h1C000; c = cyc;
    push(c + 7, mk(1'b0, 1'b0, 4'd0, 4'b0010, 17'h1C000), "t4_both_oct_mode");
    settle(10);
    check("t4_stable_three", 64'(keys_stable), 64'h1C000);
    raw = '0; settle(10);

    // 5: reset mid-debounce on key 14, with key 3 already stable
    raw = 17'h00008; c = cyc;
    push(c + 7, mk(1'b1, 1'b1, 4'd3, 4'b0000, 17'h00008), "t5_pre_press");
    settle(10);
    raw = 17'h04008; c = cyc;
    settle(4);
    rst = 1'b1;
    settle(1);
    check("t5_reset_clears", 64'(obs), 64'd0);
    rst = 1'b0;
    push(c + 12, mk(1'b1, 1'b1, 4'd3, 4'b0010, 17'h04008), "t5_after_reset");
    settle(15);
    raw = '0; c = cyc;
    push(c + 7, mk(1'b1, 1'b0, 4'd0, 4'b0000, 17'h0), "t5_release");
    settle(10);

    // 6: goof key chattering every 2 cycles
    for (int i = 0; i < 20; i++) begin
      raw[13] = ~raw[13];
      settle(2);
    end
    raw = '0;
    settle(10);
    check("t6_goof_stable", 64'(keys_stable[13]), 64'd0);

    settle(5);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
